// File: rtl/sseg_decoder.sv
// Recovers per-digit hex / minus / blank / error state from a multiplexed active-low 7-seg bus.
// Latency: a pattern held for STABLE_CYCLES sampling edges commits on the last of them; update is registered one cycle later.
// Backpressure: none; the bus is passively observed and a dwell shorter than STABLE_CYCLES never commits.
module sseg_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [6:0]              segs,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   neg_flags,
    output logic [NUM_DIGITS-1:0]   blank_flags,
    output logic [NUM_DIGITS-1:0]   err_flags,
    output logic                    update,
    output logic [2:0]              upd_idx
);

    typedef struct packed {
        logic [3:0] nib;
        logic       neg;
        logic       blank;
        logic       err;
    } slot_t;

    typedef enum logic [1:0] {K_HEX, K_NEG, K_BLANK, K_ERR} kind_t;

    localparam int              SW         = 7 + NUM_DIGITS;
    localparam logic [SW-1:0]   S1_RST     = {7'h7F, {NUM_DIGITS{1'b1}}};
    localparam logic [7:0]      CNT_MAX    = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]      CNT_COMMIT = 8'(STABLE_CYCLES - 2);
    localparam slot_t           SLOT_RST   = '{nib: 4'h0, neg: 1'b0, blank: 1'b1, err: 1'b0};

    logic [SW-1:0] s1;
    logic [7:0]    cnt;
    slot_t         slots [NUM_DIGITS];

    logic [3:0]    nz;
    logic [2:0]    sel_idx;
    logic          sel_vld;
    logic          match;
    logic          commit;
    kind_t         dec_kind;
    logic [3:0]    dec_val;
    slot_t         cur_slot;
    slot_t         nxt_slot;
    logic          changed;

    // Exactly one low select bit identifies the slot being driven.
    always_comb begin
        nz      = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) begin
                nz      = nz + 4'd1;
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_vld = (nz == 4'd1);
    assign match   = ({segs, an} == s1);
    assign commit  = !clear && sel_vld && match && (cnt == CNT_COMMIT);

    always_comb begin
        dec_kind = K_HEX;
        dec_val  = 4'h0;
        case (segs)
            7'h40: dec_val = 4'h0;
            7'h79: dec_val = 4'h1;
            7'h24: dec_val = 4'h2;
            7'h30: dec_val = 4'h3;
            7'h19: dec_val = 4'h4;
            7'h12: dec_val = 4'h5;
            7'h02: dec_val = 4'h6;
            7'h78: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h18: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
            7'h3F: dec_kind = K_NEG;
            7'h7F: dec_kind = K_BLANK;
            default: dec_kind = K_ERR;
        endcase
    end

    // Non-hex results keep the last nibble so the previous value survives a sign/blank.
    always_comb begin
        cur_slot = SLOT_RST;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == sel_idx) cur_slot = slots[i];
        end
        nxt_slot = '{nib: cur_slot.nib, neg: 1'b0, blank: 1'b0, err: 1'b0};
        case (dec_kind)
            K_HEX:   nxt_slot.nib   = dec_val;
            K_NEG:   nxt_slot.neg   = 1'b1;
            K_BLANK: nxt_slot.blank = 1'b1;
            default: nxt_slot.err   = 1'b1;
        endcase
        changed = (nxt_slot != cur_slot);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= S1_RST;
            cnt     <= '0;
            update  <= 1'b0;
            upd_idx <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= SLOT_RST;
        end else begin
            s1     <= {segs, an};
            update <= 1'b0;
            if (clear) begin
                cnt <= '0;
                for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= SLOT_RST;
            end else begin
                if (!sel_vld || !match)  cnt <= '0;
                else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
                if (commit) begin
                    upd_idx <= sel_idx;
                    update  <= changed;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (3'(i) == sel_idx) slots[i] <= nxt_slot;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
        assign digits[4*g +: 4] = slots[g].nib;
        assign neg_flags[g]     = slots[g].neg;
        assign blank_flags[g]   = slots[g].blank;
        assign err_flags[g]     = slots[g].err;
    end

endmodule

// File: doc/sseg_decoder.md
# sseg_decoder

Recovers displayed values from a multiplexed, active-low seven-segment display bus: hex digit, negative sign, or blank. Samples segment and digit-select lines on the system clock. A digit is committed only after the bus pattern has been identical for a programmable number of consecutive cycles. Results go into a per-digit register file with change notification. It sits beside the display driver path so the design and the bench can read back what the display is showing.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits; range 1–8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required to commit; range 2–255.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of register file and stability counter.
- `segs` in 7: active-low segments. Bit order {g,f,e,d,c,b,a}, with `segs[0]` = a. Synchronous to `clk`.
- `an` in NUM_DIGITS: active-low digit select; `an[i]`=0 selects digit i.
- `digits` out 4·NUM_DIGITS: nibble i at [4i+3:4i]; last decoded hex value of digit i.
- `neg_flags` out NUM_DIGITS: digit i currently shows minus.
- `blank_flags` out NUM_DIGITS: digit i currently dark.
- `err_flags` out NUM_DIGITS: digit i showed an unrecognised pattern.
- `update` out 1: one-cycle pulse when a commit changes any field of a slot.
- `upd_idx` out 3: slot index of the most recent commit.

## Operation
- Valid select: `an` has exactly one bit low. Index = position of that bit. All-high or multiple-low is invalid.
- Decode table, `segs` in hex (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E.
  - minus=3F.
  - blank=7F.
  - any other value is an error.
- Sample register `s1` holds {segs, an}. It updates every edge; reset value is {7F, all ones}.
- Stability counter `cnt`, 8 bits:
  - Input is invalid, or {segs, an} ≠ `s1`: `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1, saturating at STABLE_CYCLES−1.
- Commit fires on the edge where the inputs equal `s1`, the select is valid, and `cnt` = STABLE_CYCLES−2. At most one commit per stable run; a new commit requires an input change first.
- Commit to slot k:
  - hex: `digits[k]` ← value; neg, blank and err flags ← 0.
  - minus: neg ← 1; blank, err ← 0; nibble held.
  - blank: blank ← 1; neg, err ← 0; nibble held.
  - error: err ← 1; neg, blank ← 0; nibble held.
  - `upd_idx` ← k at every commit.
  - `update` ← 1 for one cycle only if any of nibble, neg, blank or err for slot k changed.
- Invariant: at most one of neg/blank/err is set per slot. If none is set, the nibble is meaningful.
- `clear`:
  - All slots return to reset values; `cnt` ← 0; `update` ← 0.
  - Has priority over a commit on the same edge; that commit is lost.
  - `s1` still samples.
- Reset (`rst_n`=0, any time, including mid-count):
  - `digits` = 0, `neg_flags` = 0, `blank_flags` = all ones, `err_flags` = 0.
  - `update` = 0, `upd_idx` = 0, `cnt` = 0, `s1` = {7F, all ones}.

## Timing
- Inputs presented before edge E0 and held constant are sampled at edges E0..E(S−1), with S = STABLE_CYCLES. The commit is visible on the outputs after E(S−1).
- Latency is therefore S edges from the first sampling edge, assuming the input differed before E0.
- Any change, including an `an`-only change, restarts the count at the next edge.
- `update` is high for exactly the cycle after the committing edge and is registered.
- Scan rates with dwell shorter than S cycles never commit. This is required behaviour, not an error.
- No input synchroniser. Inputs must meet setup/hold to `clk`.

## Test plan
- Reset, then hold `an`=1110 and `segs`=24 for 4 cycles (S=4) → after the 4th edge `digits[3:0]`=2, `blank_flags`[0]=0, `update` pulses once, `upd_idx`=0.
- Hold the same pattern 20 more cycles → no further `update`. Change to `segs`=00 → `digits[3:0]`=8 after 4 edges, one pulse.
- Scan digits 0..3 with 0E, 3F, 7F, 55, dwelling 6 cycles each → `digits[3:0]`=F; neg[1]=1; blank[2]=1 with no `update` (unchanged from reset); err[3]=1.
- Dwell 3 cycles per digit with S=4, any patterns → no commit, no `update`, outputs stay at reset values.
- `an`=1100 or 1111 held with valid `segs` → `cnt` stays 0, no commit.
- Assert `clear` on the exact committing edge → slot stays at reset values, `update`=0. Assert `rst_n`=0 mid-count → all outputs at reset values immediately, without waiting for a clock edge.
